debug_unit_ctrl: RTL

//  Host-facing debug controller between the UART byte link and the MIPS pipeline.

---
 rtl/debug_unit_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/debug_unit_ctrl.sv
// Host debug controller: decodes UART commands, loads instruction memory,
// controls run/step mode and streams register and pipeline-latch snapshots.
module debug_unit_ctrl #(
    parameter int unsigned MAX_INSTRUCTION = 64,
    parameter int unsigned NUM_REGISTERS   = 32,
    parameter int unsigned IF_ID_BYTES     = 4,
    parameter int unsigned ID_EX_BYTES     = 17,
    parameter int unsigned EX_MEM_BYTES    = 10,
    parameter int unsigned MEM_WB_BYTES    = 9
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [7:0]                         i_rx_data,
    input  logic                               i_rx_valid,
    output logic [7:0]                         o_tx_data,
    output logic                               o_tx_start,
    input  logic                               i_tx_done,
    output logic                               o_imem_we,
    output logic [$clog2(MAX_INSTRUCTION)-1:0] o_imem_addr,
    output logic [31:0]                        o_imem_wdata,
    output logic                               o_stall,
    output logic                               o_cpu_rst,
    output logic [2:0]                         o_dump_sel,
    output logic [7:0]                         o_dump_idx,
    input  logic [7:0]                         i_dump_byte
);

    localparam int unsigned AW = $clog2(MAX_INSTRUCTION);
    localparam logic [8:0] MaxWords = 9'(MAX_INSTRUCTION);

    typedef enum logic [3:0] {
        StIdle, StLdCnt, StLdByte, StLdWr, StDumpReq, StDumpTx, StDumpWait, StAckTx, StAckWait
    } state_e;

    state_e      state_q, state_d;
    logic        cont_q, cont_d;
    logic        stall_q, stall_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  word_q, word_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] wdata_q, wdata_d;
    logic [8:0]  dump_len;
    logic [8:0]  idx_inc;

    always_comb begin
        dump_len = 9'd1;
        case (sel_q)
            3'd1:    dump_len = 9'(4 * NUM_REGISTERS);
            3'd2:    dump_len = 9'(IF_ID_BYTES);
            3'd3:    dump_len = 9'(ID_EX_BYTES);
            3'd4:    dump_len = 9'(EX_MEM_BYTES);
            3'd5:    dump_len = 9'(MEM_WB_BYTES);
            default: dump_len = 9'd1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cont_d     = cont_q;
        stall_d    = 1'b1;
        cpu_rst_d  = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        byte_d     = byte_q;
        wdata_d    = wdata_q;
        idx_inc    = {1'b0, idx_q} + 9'd1;
        case (state_q)
            StIdle: begin
                stall_d = ~cont_q;
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h08: begin
                            cont_d  = 1'b1;
                            stall_d = 1'b0;
                        end
                        8'h11: begin
                            cont_d  = 1'b0;
                            state_d = StAckTx;
                        end
                        // Single-step: one free-running cycle, then the default re-freezes.
                        8'h0A: if (!cont_q) stall_d = 1'b0;
                        8'h07: state_d = StLdCnt;
                        8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
                            sel_d   = i_rx_data[2:0];
                            idx_d   = 8'd0;
                            state_d = StDumpReq;
                        end
                        default: ;
                    endcase
                end
            end
            StLdCnt: begin
                if (i_rx_valid) begin
                    cnt_d  = i_rx_data;
                    word_d = 8'd0;
                    byte_d = 2'd0;
                    if (i_rx_data == 8'd0) begin
                        cpu_rst_d = 1'b1;
                        state_d   = StAckTx;
                    end else begin
                        state_d = StLdByte;
                    end
                end
            end
            StLdByte: begin
                if (i_rx_valid) begin
                    wdata_d = {i_rx_data, wdata_q[31:8]};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = StLdWr;
                end
            end
            StLdWr: begin
                word_d = word_q + 8'd1;
                if (word_q == cnt_q - 8'd1) begin
                    cpu_rst_d = 1'b1;
                    state_d   = StAckTx;
                end else begin
                    state_d = StLdByte;
                    // A byte landing during the write cycle starts the next word.
                    if (i_rx_valid) begin
                        wdata_d = {i_rx_data, wdata_q[31:8]};
                        byte_d  = 2'd1;
                    end
                end
            end
            StDumpReq: state_d = StDumpTx;
            StDumpTx: begin
                tx_data_d  = i_dump_byte;
                tx_start_d = 1'b1;
                state_d    = StDumpWait;
            end
            StDumpWait: begin
                if (i_tx_done) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_inc < dump_len) ? StDumpReq : StAckTx;
                end
            end
            StAckTx: begin
                tx_data_d  = 8'h52;
                tx_start_d = 1'b1;
                state_d    = StAckWait;
            end
            StAckWait: if (i_tx_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cont_q     <= 1'b0;
            stall_q    <= 1'b1;
            cpu_rst_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            sel_q      <= 3'd0;
            idx_q      <= 8'd0;
            cnt_q      <= 8'd0;
            word_q     <= 8'd0;
            byte_q     <= 2'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cont_q     <= cont_d;
            stall_q    <= stall_d;
            cpu_rst_q  <= cpu_rst_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            wdata_q    <= wdata_d;
        end
    end

    // Strobes are masked by reset so nothing escapes during the reset cycle.
    assign o_imem_we    = (state_q == StLdWr) && ({1'b0, word_q} < MaxWords) && !i_rst;
    assign o_tx_start   = tx_start_q && !i_rst;
    assign o_imem_addr  = word_q[AW-1:0];
    assign o_imem_wdata = wdata_q;
    assign o_tx_data    = tx_data_q;
    assign o_stall      = stall_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_dump_sel   = sel_q;
    assign o_dump_idx   = idx_q;

endmodule
